pong_match_fsm: RTL and testbench

Match-level sequencer for the Pong console. It owns the game state, both scores and the serve/point pauses, which it times from the per-frame tick. It drives reset_game into both paddle controllers and the run/serve controls into the ball block. It consumes the ball's miss strobes and produces score and state values for the renderer.

---
 rtl/pong_match_if.sv | 30 +++
 rtl/pong_match_fsm.sv | 187 ++++++++++++++++++
 tb/tb_pong_match_fsm.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pong_match_if.sv
// Match-sequencer bundle: player/ball events in, paddle/ball controls and renderer state out.
// master is the sequencer side, slave is the console side driving events and consuming controls.
interface pong_match_if #(
  parameter int SCORE_W = 4
);
  logic               start_btn;
  logic               frame_tick;
  logic               miss_left;
  logic               miss_right;
  logic               reset_game;
  logic               ball_run;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_left;
  logic [SCORE_W-1:0] score_right;
  logic [2:0]         state;
  logic               game_over;
  logic               winner;

  modport master (
    input  start_btn, frame_tick, miss_left, miss_right,
    output reset_game, ball_run, serve_dir, score_left, score_right,
           state, game_over, winner
  );

  modport slave (
    output start_btn, frame_tick, miss_left, miss_right,
    input  reset_game, ball_run, serve_dir, score_left, score_right,
           state, game_over, winner
  );
endinterface

// File: rtl/pong_match_fsm.sv
// Pong match sequencer: scores, serve/point pauses timed in frame ticks; all outputs registered,
// events act at the next edge, no backpressure. PONG_AUTO_RESTART_EN adds GAME_OVER timeout to IDLE.
module pong_match_fsm #(
  parameter int WIN_SCORE       = 7,
  parameter int SCORE_W         = 4,
  parameter int SERVE_FRAMES    = 60,
  parameter int POINT_FRAMES    = 90,
  parameter int GAMEOVER_FRAMES = 300
) (
  input  logic          clk,
  input  logic          rst,
  pong_match_if.master  bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] SERVE     = 3'd1;
  localparam logic [2:0] PLAY      = 3'd2;
  localparam logic [2:0] POINT     = 3'd3;
  localparam logic [2:0] GAME_OVER = 3'd4;

  localparam logic [8:0]         SERVE_N = 9'(SERVE_FRAMES);
  localparam logic [8:0]         POINT_N = 9'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] WIN_N   = SCORE_W'(WIN_SCORE);
`ifdef PONG_AUTO_RESTART_EN
  localparam logic [8:0]         GO_N    = 9'(GAMEOVER_FRAMES);
`endif

  if (WIN_SCORE >= (1 << SCORE_W)) begin : g_bad_win
    $error("WIN_SCORE does not fit in SCORE_W bits");
  end
  if (SERVE_FRAMES > 511 || POINT_FRAMES > 511 || GAMEOVER_FRAMES > 511) begin : g_bad_frames
    $error("frame counts must fit the 9-bit frame counter");
  end

  logic [2:0]         state_q;
  logic [8:0]         cnt_q;
  logic               start_q;
  logic [SCORE_W-1:0] score_left_q;
  logic [SCORE_W-1:0] score_right_q;
  logic               reset_game_q;
  logic               ball_run_q;
  logic               serve_dir_q;
  logic               game_over_q;
  logic               winner_q;

  logic               start_evt;
  logic [8:0]         cnt_inc;
  logic [SCORE_W-1:0] sl_inc;
  logic [SCORE_W-1:0] sr_inc;

  assign start_evt = bus.start_btn & ~start_q;
  assign cnt_inc   = cnt_q + 9'd1;
  assign sl_inc    = score_left_q + SCORE_W'(1);
  assign sr_inc    = score_right_q + SCORE_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      start_q       <= 1'b0;
      score_left_q  <= '0;
      score_right_q <= '0;
      reset_game_q  <= 1'b1;
      ball_run_q    <= 1'b0;
      serve_dir_q   <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      start_q <= bus.start_btn;
      case (state_q)
        IDLE: begin
          reset_game_q <= 1'b1;
          ball_run_q   <= 1'b0;
          if (start_evt) begin
            state_q       <= SERVE;
            cnt_q         <= '0;
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= 1'b0;
            reset_game_q  <= 1'b0;
          end
        end

        SERVE: begin
          // clears the one-cycle recentre pulse issued on restart from GAME_OVER
          reset_game_q <= 1'b0;
          if (bus.frame_tick) begin
            if (cnt_inc == SERVE_N) begin
              state_q    <= PLAY;
              cnt_q      <= '0;
              ball_run_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        PLAY: begin
          if (bus.miss_left && bus.miss_right) begin
            state_q    <= POINT;
            cnt_q      <= '0;
            ball_run_q <= 1'b0;
          end else if (bus.miss_left) begin
            score_right_q <= sr_inc;
            serve_dir_q   <= 1'b0;
            cnt_q         <= '0;
            ball_run_q    <= 1'b0;
            if (sr_inc == WIN_N) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
              winner_q    <= 1'b1;
            end else begin
              state_q <= POINT;
            end
          end else if (bus.miss_right) begin
            score_left_q <= sl_inc;
            serve_dir_q  <= 1'b1;
            cnt_q        <= '0;
            ball_run_q   <= 1'b0;
            if (sl_inc == WIN_N) begin
              state_q     <= GAME_OVER;
              game_over_q <= 1'b1;
              winner_q    <= 1'b0;
            end else begin
              state_q <= POINT;
            end
          end
        end

        POINT: begin
          if (bus.frame_tick) begin
            if (cnt_inc == POINT_N) begin
              state_q <= SERVE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end

        GAME_OVER: begin
          if (start_evt) begin
            state_q       <= SERVE;
            cnt_q         <= '0;
            score_left_q  <= '0;
            score_right_q <= '0;
            serve_dir_q   <= 1'b0;
            game_over_q   <= 1'b0;
            reset_game_q  <= 1'b1;
          end
`ifdef PONG_AUTO_RESTART_EN
          else if (bus.frame_tick) begin
            if (cnt_inc == GO_N) begin
              state_q       <= IDLE;
              cnt_q         <= '0;
              score_left_q  <= '0;
              score_right_q <= '0;
              game_over_q   <= 1'b0;
              reset_game_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
`endif
        end

        default: begin
          state_q      <= IDLE;
          cnt_q        <= '0;
          reset_game_q <= 1'b1;
          ball_run_q   <= 1'b0;
          game_over_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reset_game  = reset_game_q;
  assign bus.ball_run    = ball_run_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.score_left  = score_left_q;
  assign bus.score_right = score_right_q;
  assign bus.state       = state_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_match_fsm.sv
// Directed bench for pong_match_fsm with default parameters; define PONG_AUTO_RESTART_EN
// here too when building the auto-restart variant.
module tb_pong_match_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pong_match_if #(.SCORE_W(4)) bus ();

  pong_match_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
    end
  endtask

  task automatic miss(input logic l, input logic r);
    @(negedge clk);
    bus.miss_left  = l;
    bus.miss_right = r;
    @(negedge clk);
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
  endtask

  task automatic press_start();
    @(negedge clk) bus.start_btn = 1'b1;
    @(negedge clk) bus.start_btn = 1'b0;
  endtask

  // one point scored, then the full POINT and SERVE pauses back into PLAY
  task automatic score_point(input logic l, input logic r);
    miss(l, r);
    frames(90);
    frames(60);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.reset_game !== 1'b1) begin errors++; $display("FAIL reset_reset_game got=%b exp=1", bus.reset_game); end
    checks++; if (bus.ball_run !== 1'b0) begin errors++; $display("FAIL reset_ball_run got=%b exp=0", bus.ball_run); end
    checks++; if (bus.score_left !== 4'd0 || bus.score_right !== 4'd0) begin errors++; $display("FAIL reset_scores got=%0d/%0d exp=0/0", bus.score_left, bus.score_right); end
    checks++; if (bus.game_over !== 1'b0 || bus.winner !== 1'b0 || bus.serve_dir !== 1'b0) begin errors++; $display("FAIL reset_flags got go=%b w=%b sd=%b exp=0/0/0", bus.game_over, bus.winner, bus.serve_dir); end
  endtask

  task automatic test_start_held();
    int bad = 0;
    @(negedge clk) bus.start_btn = 1'b1;
    @(negedge clk);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL start_serve got=%0d exp=1", bus.state); end
    checks++; if (bus.reset_game !== 1'b0) begin errors++; $display("FAIL start_reset_game got=%b exp=0", bus.reset_game); end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.state !== 3'd1) bad++;
    end
    bus.start_btn = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL start_held_stable cycles_off_serve=%0d exp=0", bad); end
    frames(59);
    checks++; if (bus.state !== 3'd1 || bus.ball_run !== 1'b0) begin errors++; $display("FAIL serve_59 got state=%0d run=%b exp=1/0", bus.state, bus.ball_run); end
    frames(1);
    checks++; if (bus.state !== 3'd2 || bus.ball_run !== 1'b1) begin errors++; $display("FAIL serve_60 got state=%0d run=%b exp=2/1", bus.state, bus.ball_run); end
    press_start();
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL start_in_play got=%0d exp=2", bus.state); end
  endtask

  task automatic test_point();
    miss(1'b1, 1'b0);
    checks++; if (bus.score_right !== 4'd1 || bus.score_left !== 4'd0) begin errors++; $display("FAIL point_score got=%0d/%0d exp=0/1", bus.score_left, bus.score_right); end
    checks++; if (bus.state !== 3'd3 || bus.serve_dir !== 1'b0 || bus.ball_run !== 1'b0) begin errors++; $display("FAIL point_state got st=%0d sd=%b run=%b exp=3/0/0", bus.state, bus.serve_dir, bus.ball_run); end
    miss(1'b1, 1'b0);
    checks++; if (bus.score_right !== 4'd1 || bus.state !== 3'd3) begin errors++; $display("FAIL miss_in_point got sr=%0d st=%0d exp=1/3", bus.score_right, bus.state); end
    frames(89);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL point_89 got=%0d exp=3", bus.state); end
    frames(1);
    checks++; if (bus.state !== 3'd1 || bus.reset_game !== 1'b0) begin errors++; $display("FAIL point_90 got st=%0d rg=%b exp=1/0", bus.state, bus.reset_game); end
    frames(60);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL point_reserve got=%0d exp=2", bus.state); end
  endtask

  task automatic test_both_miss();
    score_point(1'b0, 1'b1);
    checks++; if (bus.score_left !== 4'd1 || bus.serve_dir !== 1'b1) begin errors++; $display("FAIL miss_right got sl=%0d sd=%b exp=1/1", bus.score_left, bus.serve_dir); end
    miss(1'b1, 1'b1);
    checks++; if (bus.score_left !== 4'd1 || bus.score_right !== 4'd1) begin errors++; $display("FAIL both_scores got=%0d/%0d exp=1/1", bus.score_left, bus.score_right); end
    checks++; if (bus.state !== 3'd3 || bus.serve_dir !== 1'b1) begin errors++; $display("FAIL both_state got st=%0d sd=%b exp=3/1", bus.state, bus.serve_dir); end
    frames(150);
  endtask

  task automatic test_win_left();
    for (int i = 0; i < 5; i++) score_point(1'b0, 1'b1);
    checks++; if (bus.score_left !== 4'd6 || bus.state !== 3'd2) begin errors++; $display("FAIL pre_win got sl=%0d st=%0d exp=6/2", bus.score_left, bus.state); end
    miss(1'b0, 1'b1);
    checks++; if (bus.score_left !== 4'd7 || bus.state !== 3'd4) begin errors++; $display("FAIL win_left got sl=%0d st=%0d exp=7/4", bus.score_left, bus.state); end
    checks++; if (bus.game_over !== 1'b1 || bus.winner !== 1'b0 || bus.ball_run !== 1'b0) begin errors++; $display("FAIL win_left_flags got go=%b w=%b run=%b exp=1/0/0", bus.game_over, bus.winner, bus.ball_run); end
    miss(1'b1, 1'b0);
    miss(1'b0, 1'b1);
    frames(5);
    checks++; if (bus.score_left !== 4'd7 || bus.score_right !== 4'd1 || bus.state !== 3'd4 || bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin errors++; $display("FAIL gameover_frozen got sl=%0d sr=%0d st=%0d go=%b w=%b exp=7/1/4/1/0", bus.score_left, bus.score_right, bus.state, bus.game_over, bus.winner); end
  endtask

  task automatic test_restart();
    press_start();
    checks++; if (bus.state !== 3'd1 || bus.game_over !== 1'b0) begin errors++; $display("FAIL restart_state got st=%0d go=%b exp=1/0", bus.state, bus.game_over); end
    checks++; if (bus.score_left !== 4'd0 || bus.score_right !== 4'd0 || bus.serve_dir !== 1'b0) begin errors++; $display("FAIL restart_scores got=%0d/%0d sd=%b exp=0/0/0", bus.score_left, bus.score_right, bus.serve_dir); end
    checks++; if (bus.reset_game !== 1'b1) begin errors++; $display("FAIL restart_pulse_hi got=%b exp=1", bus.reset_game); end
    @(negedge clk);
    checks++; if (bus.reset_game !== 1'b0) begin errors++; $display("FAIL restart_pulse_lo got=%b exp=0", bus.reset_game); end
  endtask

  task automatic test_async_reset();
    frames(60);
    score_point(1'b0, 1'b1);
    checks++; if (bus.state !== 3'd2 || bus.serve_dir !== 1'b1 || bus.score_left !== 4'd1) begin errors++; $display("FAIL pre_reset got st=%0d sd=%b sl=%0d exp=2/1/1", bus.state, bus.serve_dir, bus.score_left); end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.state !== 3'd0 || bus.ball_run !== 1'b0 || bus.reset_game !== 1'b1) begin errors++; $display("FAIL async_reset got st=%0d run=%b rg=%b exp=0/0/1", bus.state, bus.ball_run, bus.reset_game); end
    checks++; if (bus.score_left !== 4'd0 || bus.serve_dir !== 1'b0) begin errors++; $display("FAIL async_reset_regs got sl=%0d sd=%b exp=0/0", bus.score_left, bus.serve_dir); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_win_right_and_timeout();
    press_start();
    frames(60);
    for (int i = 0; i < 6; i++) score_point(1'b1, 1'b0);
    miss(1'b1, 1'b0);
    checks++; if (bus.score_right !== 4'd7 || bus.state !== 3'd4 || bus.winner !== 1'b1 || bus.game_over !== 1'b1) begin errors++; $display("FAIL win_right got sr=%0d st=%0d w=%b go=%b exp=7/4/1/1", bus.score_right, bus.state, bus.winner, bus.game_over); end
`ifdef PONG_AUTO_RESTART_EN
    frames(299);
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL timeout_299 got=%0d exp=4", bus.state); end
    frames(1);
    checks++; if (bus.state !== 3'd0 || bus.reset_game !== 1'b1 || bus.game_over !== 1'b0 || bus.score_right !== 4'd0) begin errors++; $display("FAIL timeout_300 got st=%0d rg=%b go=%b sr=%0d exp=0/1/0/0", bus.state, bus.reset_game, bus.game_over, bus.score_right); end
`else
    frames(300);
    checks++; if (bus.state !== 3'd4 || bus.game_over !== 1'b1 || bus.score_right !== 4'd7) begin errors++; $display("FAIL gameover_persist got st=%0d go=%b sr=%0d exp=4/1/7", bus.state, bus.game_over, bus.score_right); end
`endif
  endtask

  initial begin
    bus.start_btn  = 1'b0;
    bus.frame_tick = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    test_reset();
    test_start_held();
    test_point();
    test_both_miss();
    test_win_left();
    test_restart();
    test_async_reset();
    test_win_right_and_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
